// File: rtl/key_cond.sv
// key_cond: debounces four active-low buttons into a one-hot keyin vector.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_cond #(
    parameter int DB_CYCLES = 50000,
    parameter int REP_DELAY = 12500000,
    parameter int REP_GAP   = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic [3:0] keyin
);

    localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    if (DB_CYCLES < 1 || DB_CYCLES > 20'hfffff || REP_DELAY < 1 || REP_GAP < 1) begin : g_cfg_err
        $error("key_cond: illegal DB_CYCLES/REP_DELAY/REP_GAP");
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_GAP) ? REP_DELAY : REP_GAP;
    localparam int HW   = $clog2(RMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REP_DELAY - 1);
    localparam logic [HW-1:0] GAP_LAST  = HW'(REP_GAP - 1);

    typedef enum logic [2:0] {IDLE, ARM, HOLD, REL, GAP} state_t;

    logic [HW-1:0] hcnt, hcnt_d;
`else
    typedef enum logic [2:0] {IDLE, ARM, HOLD, REL} state_t;
`endif

    state_t      state, state_d;
    logic [3:0]  s1, s2;
    logic [3:0]  k;
    logic [3:0]  cand, cand_d;
    logic [19:0] cnt, cnt_d;
    logic [3:0]  keyin_d;

    assign k = ~s2;

    // Two-flop synchronizer; reset to "all released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 4'b1111;
            s2 <= 4'b1111;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // State, candidate, counters and the registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cand  <= 4'b0000;
            cnt   <= '0;
            keyin <= 4'b0000;
`ifdef KEY_REPEAT_EN
            hcnt  <= '0;
`endif
        end else begin
            state <= state_d;
            cand  <= cand_d;
            cnt   <= cnt_d;
            keyin <= keyin_d;
`ifdef KEY_REPEAT_EN
            hcnt  <= hcnt_d;
`endif
        end
    end

    // Next-state logic; keyin follows the candidate only while HOLD/REL.
    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
`ifdef KEY_REPEAT_EN
        hcnt_d  = hcnt;
`endif
        case (state)
            IDLE: begin
                if ($onehot(k)) begin
                    cand_d  = k;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (k != cand) begin
                    state_d = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_d = HOLD;
`ifdef KEY_REPEAT_EN
                    hcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt + 20'd1;
                end
            end
            HOLD: begin
                if (k != cand) begin
                    state_d = REL;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (hcnt == HOLD_LAST) begin
                    state_d = GAP;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
`endif
            end
            REL: begin
                if (k == cand) begin
                    state_d = HOLD;
                end else if (cnt == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 20'd1;
                end
            end
`ifdef KEY_REPEAT_EN
            GAP: begin
                if (hcnt == GAP_LAST) begin
                    hcnt_d  = '0;
                    state_d = (k == cand) ? HOLD : IDLE;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        keyin_d = (state_d == HOLD || state_d == REL) ? cand_d : 4'b0000;
    end

endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond: directed checks of key_cond with DB_CYCLES=4.
// Auto-repeat expectations apply when KEY_REPEAT_EN is defined.
module tb_key_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic [3:0] keyin;

    int npass  = 0;
    int ntotal = 0;

    key_cond #(
        .DB_CYCLES(4),
        .REP_DELAY(10),
        .REP_GAP  (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_n),
        .keyin(keyin)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        ntotal++;
        assert (keyin === exp) npass++;
        else $error("FAIL %s: keyin=%b expected %b", tag, keyin, exp);
    endtask

    task automatic release_all();
        key_n = 4'b1111;
        tick(10);
        check("idle", 4'b0000);
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 4'b1110;
        tick(3);
        check("rst_hold", 4'b0000);

        // Reset release with right held: 7 edges to assert.
        rst = 1'b0;
        tick(6);
        check("rst_pre", 4'b0000);
        tick(1);
        check("rst_lat", 4'b0001);

        // Clean release: 7 edges to drop.
        key_n = 4'b1111;
        tick(6);
        check("rel_pre", 4'b0001);
        tick(1);
        check("rel_lat", 4'b0000);

        // Async reset while a key is asserted.
        key_n = 4'b1110;
        tick(7);
        check("pre_arst", 4'b0001);
        #2 rst = 1'b1;
        #1 check("arst", 4'b0000);
        tick(1);
        rst = 1'b0;
        tick(6);
        check("rearm_pre", 4'b0000);
        tick(1);
        check("rearm", 4'b0001);
        release_all();

        // Bouncy press on down.
        key_n = 4'b1011; tick(1);
        key_n = 4'b1111; tick(1);
        key_n = 4'b1011; tick(1);
        key_n = 4'b1111; tick(1);
        check("bounce_mid", 4'b0000);
        key_n = 4'b1011;
        tick(6);
        check("bounce_pre", 4'b0000);
        tick(1);
        check("bounce_lat", 4'b0100);
        release_all();

        // Release with a 2-cycle glitch back to pressed.
        key_n = 4'b0111;
        tick(7);
        check("up_press", 4'b1000);
        key_n = 4'b1111; tick(2);
        key_n = 4'b0111; tick(2);
        check("glitch_mid", 4'b1000);
        key_n = 4'b1111;
        tick(6);
        check("glitch_pre", 4'b1000);
        tick(1);
        check("glitch_rel", 4'b0000);
        release_all();

        // Two keys together never arm.
        key_n = 4'b0011;
        tick(20);
        check("multi_hot", 4'b0000);
        key_n = 4'b0111;
        tick(6);
        check("multi_pre", 4'b0000);
        tick(1);
        check("multi_one", 4'b1000);
        release_all();

        // Key roll: left, add right, drop left.
        key_n = 4'b1101;
        tick(7);
        check("roll_left", 4'b0010);
        key_n = 4'b1100;
        tick(6);
        check("roll_pre", 4'b0010);
        tick(1);
        check("roll_gap", 4'b0000);
        tick(20);
        check("roll_both", 4'b0000);
        key_n = 4'b1110;
        tick(6);
        check("roll_pre2", 4'b0000);
        tick(1);
        check("roll_right", 4'b0001);
        release_all();

        // Long hold of up for 60 cycles.
        key_n = 4'b0111;
        tick(7);
        check("hold_0", 4'b1000);
        for (int j = 1; j < 60; j++) begin
            tick(1);
`ifdef KEY_REPEAT_EN
            check("repeat", ((j % 13) < 10) ? 4'b1000 : 4'b0000);
`else
            check("hold", 4'b1000);
`endif
        end
        release_all();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
